register_bank: RTL
==================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter ZERO_R0, default 1: when 1, R0 is hardwired to 32'h00000000 and writes to address 0 are discarded.
REQ-002 Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-004 RegWrite  input  1  write enable; a write occurs on each rising Clk edge where RegWrite=1.
REQ-005 WriteReg  input  5  destination register index, 0..31.
REQ-006 WriteData  input  32  data written to register WriteReg.
REQ-007 R0 .. R31  output  32 each  current contents of registers 0..31; they connect one-to-one to the 32:1 read multiplexer inputs R0..R31.
REQ-008 Written  output  32  bit i = 1 when register i has accepted a write since the last reset.
REQ-009 WriteCount  output  8  number of accepted writes since reset, modulo 256.

Function
REQ-010 Storage: 32 registers, each 32 bits; outputs R0..R31 shall be driven directly from register state, with no combinational path from WriteData to any Ri.
REQ-011 Write latency: data presented with RegWrite=1 at edge N shall appear on R[WriteReg] immediately after edge N and be stable for the whole following cycle; there is no read-during-write bypass.
REQ-012 Decode: exactly one register, R[WriteReg], updates per accepted write; all other registers hold.
REQ-013 RegWrite=0: no register, no Written bit and no WriteCount change, whatever WriteReg and WriteData are.
REQ-014 Accepted write: a write with RegWrite=1, except a write to address 0 when ZERO_R0=1.
REQ-015 ZERO_R0=1, WriteReg=0, RegWrite=1: R0 stays 0, Written[0] stays 0, WriteCount does not increment.
REQ-016 ZERO_R0=0: R0 behaves as a general register.
REQ-017 Written[i] shall set on the first accepted write to register i and stay set until reset; rewriting a register leaves its bit at 1.
REQ-018 WriteCount shall increment by 1 on each accepted write and wrap from 255 to 0.
REQ-019 Repeated writes to the same register on consecutive cycles: each cycle's WriteData shall replace the previous value, and WriteCount shall increment every cycle.
REQ-020 Unknown inputs: when RegWrite=0, WriteReg and WriteData are don't-care and shall not affect state.

Reset
REQ-021 When Reset=1 at a rising Clk edge, R0..R31, Written and WriteCount shall all clear to 0 after that edge.
REQ-022 Reset has priority over write: when Reset=1 and RegWrite=1 at the same edge, the write is dropped and every register reads 0.
REQ-023 Reset asserted in the middle of a write sequence: registers written before the reset edge shall read 0 afterwards, and writes resume normally on the first edge with Reset=0.
REQ-024 Before the first reset, output values are undefined; the bench shall apply Reset for at least 1 cycle before checking.

Verification
REQ-025 Reset, then write Ri = 32'h1 << i for i=1..31 on consecutive cycles.
- Each Ri matches the value one cycle after its write.
- WriteCount ends at 31.
- Written = 32'hFFFFFFFE.
REQ-026 ZERO_R0=1: write R0 = 32'hDEADBEEF.
- R0 stays 0.
- Written[0] stays 0.
- WriteCount does not change.
- Repeat with ZERO_R0=0: R0 = 32'hDEADBEEF and WriteCount increments by 1.
REQ-027 Hold RegWrite=0 for 10 cycles while toggling WriteReg and WriteData randomly.
- All Ri, Written and WriteCount stay unchanged.
REQ-028 Reset priority: load R5 = 32'hA5A5A5A5, then assert Reset with RegWrite=1, WriteReg=5, WriteData=32'h12345678 on the same edge.
- R5 = 0, Written = 0 and WriteCount = 0 afterwards.
REQ-029 Perform 256 accepted writes to R7, with data equal to the cycle index.
- WriteCount wraps to 0.
- R7 = 32'd255.
REQ-030 Connect register_bank to the 32:1 read multiplexer and sweep the select 0..31 after REQ-025.
- Mux output equals 32'h1 << select for select 1..31.
- Mux output equals 0 for select 0.

Source files
------------

// File: rtl/register_bank.sv
// Register bank with 32 x 32-bit registers, all contents exposed in parallel for an external read mux.
// It also tracks which registers have been written and counts accepted writes.
module register_bank #(
    parameter int ZERO_R0 = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RegWrite,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    output logic [31:0] R0,
    output logic [31:0] R1,
    output logic [31:0] R2,
    output logic [31:0] R3,
    output logic [31:0] R4,
    output logic [31:0] R5,
    output logic [31:0] R6,
    output logic [31:0] R7,
    output logic [31:0] R8,
    output logic [31:0] R9,
    output logic [31:0] R10,
    output logic [31:0] R11,
    output logic [31:0] R12,
    output logic [31:0] R13,
    output logic [31:0] R14,
    output logic [31:0] R15,
    output logic [31:0] R16,
    output logic [31:0] R17,
    output logic [31:0] R18,
    output logic [31:0] R19,
    output logic [31:0] R20,
    output logic [31:0] R21,
    output logic [31:0] R22,
    output logic [31:0] R23,
    output logic [31:0] R24,
    output logic [31:0] R25,
    output logic [31:0] R26,
    output logic [31:0] R27,
    output logic [31:0] R28,
    output logic [31:0] R29,
    output logic [31:0] R30,
    output logic [31:0] R31,
    output logic [31:0] Written,
    output logic [7:0]  WriteCount
);

    logic [31:0] regs [32];
    logic        accept;

    // A write to R0 is dropped entirely when R0 is hardwired, so it must not touch the bookkeeping.
    assign accept = RegWrite && !((ZERO_R0 != 0) && (WriteReg == 5'd0));

    // NOTE: every register is cleared by reset, so this array is built from flops rather than
    // a RAM macro; the parallel R0..R31 outputs need flops anyway.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            Written    <= '0;
            WriteCount <= '0;
        end else if (accept) begin
            regs[WriteReg]    <= WriteData;
            Written[WriteReg] <= 1'b1;
            WriteCount        <= WriteCount + 8'd1;
        end
    end

    assign R0  = regs[0];
    assign R1  = regs[1];
    assign R2  = regs[2];
    assign R3  = regs[3];
    assign R4  = regs[4];
    assign R5  = regs[5];
    assign R6  = regs[6];
    assign R7  = regs[7];
    assign R8  = regs[8];
    assign R9  = regs[9];
    assign R10 = regs[10];
    assign R11 = regs[11];
    assign R12 = regs[12];
    assign R13 = regs[13];
    assign R14 = regs[14];
    assign R15 = regs[15];
    assign R16 = regs[16];
    assign R17 = regs[17];
    assign R18 = regs[18];
    assign R19 = regs[19];
    assign R20 = regs[20];
    assign R21 = regs[21];
    assign R22 = regs[22];
    assign R23 = regs[23];
    assign R24 = regs[24];
    assign R25 = regs[25];
    assign R26 = regs[26];
    assign R27 = regs[27];
    assign R28 = regs[28];
    assign R29 = regs[29];
    assign R30 = regs[30];
    assign R31 = regs[31];

endmodule
